switch_rr_arbiter: RTL and testbench

- Round-robin arbiter that shares the single display/indicator resource among up to NUM_REQ switch requesters.
- Replaces fixed-priority switch encoding with fair, time-sliced grants. Each grant is held for a bounded number of cycles.
- Exports the granted index as binary and as two decimal digits for the existing hex-to-seven-segment converter.
- Sits between SWITCH_I and the seven-segment/LED output logic in the top-level.

---
 rtl/switch_rr_arbiter.sv | 200 ++++++++++++++++++++
 tb/tb_switch_rr_arbiter.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/switch_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : switch_rr_arbiter
// Description : Round-robin, time-sliced arbiter sharing one display/indicator
//               resource among NUM_REQ switch requesters. Exports the granted
//               index in binary and as two decimal digits, plus a saturating
//               grant counter.
// Revision    : 1.0 - initial release
// ============================================================================
module switch_rr_arbiter #(
  parameter int NUM_REQ     = 18,
  parameter int HOLD_CYCLES = 50000000
) (
  input  logic               CLOCK_50_I,
  input  logic               RESETN_I,
  input  logic [NUM_REQ-1:0] REQ_I,
  input  logic               ENABLE_I,
  output logic [NUM_REQ-1:0] GRANT_O,
  output logic               GRANT_VALID_O,
  output logic [4:0]         GRANT_IDX_O,
  output logic [3:0]         GRANT_TENS_O,
  output logic [3:0]         GRANT_ONES_O,
  output logic [15:0]        GRANT_COUNT_O
);

  // Hold counter only needs to reach HOLD_CYCLES-1.
  localparam int c_CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [c_CNT_W-1:0] c_HOLD_LAST = c_CNT_W'(HOLD_CYCLES - 1);
  localparam logic [4:0] c_LAST_RST = 5'(NUM_REQ - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_GRANT = 2'd1;
  localparam logic [1:0] S_GAP   = 2'd2;

  logic [1:0]         r_state;
  logic [NUM_REQ-1:0] r_grant;
  logic               r_valid;
  logic [4:0]         r_idx;
  logic [3:0]         r_tens;
  logic [3:0]         r_ones;
  logic [15:0]        r_count;
  logic [4:0]         r_last;
  logic [c_CNT_W-1:0] r_hold;

  logic [1:0]         w_state_nxt;
  logic [NUM_REQ-1:0] w_grant_nxt;
  logic               w_valid_nxt;
  logic [4:0]         w_idx_nxt;
  logic [3:0]         w_tens_nxt;
  logic [3:0]         w_ones_nxt;
  logic [15:0]        w_count_nxt;
  logic [4:0]         w_last_nxt;
  logic [c_CNT_W-1:0] w_hold_nxt;

  logic [NUM_REQ-1:0] w_mask_hi;
  logic [NUM_REQ-1:0] w_req_hi;
  logic [4:0]         w_win_hi;
  logic [4:0]         w_win_lo;
  logic [4:0]         w_winner;
  logic [NUM_REQ-1:0] w_onehot;
  logic [3:0]         w_tens;
  logic [3:0]         w_ones;
  logic               w_arb;
  logic               w_release;

  // Requests strictly above the last-served index get first chance; the
  // wrap-around search falls back to the lowest set bit overall.
  always_comb begin
    w_mask_hi = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_mask_hi[i] = (5'(i) > r_last);
    end
  end

  assign w_req_hi = REQ_I & w_mask_hi;

  // Lowest-set-bit encoders for the upper slice and for the full vector.
  always_comb begin
    w_win_hi = '0;
    w_win_lo = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (w_req_hi[i]) w_win_hi = 5'(i);
      if (REQ_I[i])    w_win_lo = 5'(i);
    end
  end

  assign w_winner = (|w_req_hi) ? w_win_hi : w_win_lo;
  assign w_arb    = ENABLE_I && (|REQ_I);

  // One-hot decode of the winner.
  always_comb begin
    w_onehot = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_onehot[i] = (5'(i) == w_winner);
    end
  end

  // Binary-to-two-digit decimal split for indices 0..31.
  always_comb begin
    w_tens = 4'd0;
    w_ones = 4'(w_winner);
    if (w_winner >= 5'd30) begin
      w_tens = 4'd3;
      w_ones = 4'(w_winner - 5'd30);
    end else if (w_winner >= 5'd20) begin
      w_tens = 4'd2;
      w_ones = 4'(w_winner - 5'd20);
    end else if (w_winner >= 5'd10) begin
      w_tens = 4'd1;
      w_ones = 4'(w_winner - 5'd10);
    end
  end

  // Grant ends on time-out, on the holder dropping its request, or on disable.
  assign w_release = (r_hold == c_HOLD_LAST) || !(|(r_grant & REQ_I)) || !ENABLE_I;

  // State and output registers.
  always_ff @(posedge CLOCK_50_I or negedge RESETN_I) begin
    if (!RESETN_I) begin
      r_state <= S_IDLE;
      r_grant <= '0;
      r_valid <= 1'b0;
      r_idx   <= 5'd0;
      r_tens  <= 4'hF;
      r_ones  <= 4'hF;
      r_count <= 16'd0;
      r_last  <= c_LAST_RST;
      r_hold  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_grant <= w_grant_nxt;
      r_valid <= w_valid_nxt;
      r_idx   <= w_idx_nxt;
      r_tens  <= w_tens_nxt;
      r_ones  <= w_ones_nxt;
      r_count <= w_count_nxt;
      r_last  <= w_last_nxt;
      r_hold  <= w_hold_nxt;
    end
  end

  // Next-state selection; the gap state arbitrates exactly like idle.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE, S_GAP: w_state_nxt = w_arb ? S_GRANT : S_IDLE;
      S_GRANT:       w_state_nxt = w_release ? S_GAP : S_GRANT;
      default:       w_state_nxt = S_IDLE;
    endcase
  end

  // Next values of the registered outputs and bookkeeping.
  always_comb begin
    w_grant_nxt = r_grant;
    w_valid_nxt = r_valid;
    w_idx_nxt   = r_idx;
    w_tens_nxt  = r_tens;
    w_ones_nxt  = r_ones;
    w_count_nxt = r_count;
    w_last_nxt  = r_last;
    w_hold_nxt  = r_hold;
    case (r_state)
      S_IDLE, S_GAP: begin
        if (w_arb) begin
          w_grant_nxt = w_onehot;
          w_valid_nxt = 1'b1;
          w_idx_nxt   = w_winner;
          w_tens_nxt  = w_tens;
          w_ones_nxt  = w_ones;
          w_count_nxt = (r_count == 16'hFFFF) ? r_count : r_count + 16'd1;
          w_hold_nxt  = '0;
        end
      end
      S_GRANT: begin
        if (w_release) begin
          w_grant_nxt = '0;
          w_valid_nxt = 1'b0;
          w_tens_nxt  = 4'hF;
          w_ones_nxt  = 4'hF;
          w_last_nxt  = r_idx;
        end else begin
          w_hold_nxt  = r_hold + c_CNT_W'(1);
        end
      end
      default: begin
        w_grant_nxt = '0;
        w_valid_nxt = 1'b0;
      end
    endcase
  end

  assign GRANT_O       = r_grant;
  assign GRANT_VALID_O = r_valid;
  assign GRANT_IDX_O   = r_idx;
  assign GRANT_TENS_O  = r_tens;
  assign GRANT_ONES_O  = r_ones;
  assign GRANT_COUNT_O = r_count;

endmodule
`default_nettype wire

// File: tb/tb_switch_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_switch_rr_arbiter
// Description : Directed self-checking bench for switch_rr_arbiter with
//               NUM_REQ=18 and HOLD_CYCLES=4.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_switch_rr_arbiter;

  logic        clk;
  logic        rst_n;
  logic [17:0] req;
  logic        en;
  logic [17:0] grant;
  logic        gvalid;
  logic [4:0]  gidx;
  logic [3:0]  gtens;
  logic [3:0]  gones;
  logic [15:0] gcount;

  int n_assert;
  int n_fail;
  int exp_count;

  switch_rr_arbiter #(
    .NUM_REQ     (18),
    .HOLD_CYCLES (4)
  ) u_dut (
    .CLOCK_50_I    (clk),
    .RESETN_I      (rst_n),
    .REQ_I         (req),
    .ENABLE_I      (en),
    .GRANT_O       (grant),
    .GRANT_VALID_O (gvalid),
    .GRANT_IDX_O   (gidx),
    .GRANT_TENS_O  (gtens),
    .GRANT_ONES_O  (gones),
    .GRANT_COUNT_O (gcount)
  );

  // 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and sample 1 ns after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_grant"}, 32'(grant), 32'd0);
    chk({tag, "_valid"}, 32'(gvalid), 32'd0);
    chk({tag, "_idx"},   32'(gidx), 32'd0);
    chk({tag, "_tens"},  32'(gtens), 32'hF);
    chk({tag, "_ones"},  32'(gones), 32'hF);
    chk({tag, "_count"}, 32'(gcount), 32'd0);
  endtask

  task automatic chk_grant(input string tag, input int idx);
    logic [17:0] oh;
    oh = 18'd1;
    oh = oh << idx;
    chk({tag, "_grant"}, 32'(grant), 32'(oh));
    chk({tag, "_valid"}, 32'(gvalid), 32'd1);
    chk({tag, "_idx"},   32'(gidx), 32'(idx));
    chk({tag, "_tens"},  32'(gtens), 32'(idx / 10));
    chk({tag, "_ones"},  32'(gones), 32'(idx % 10));
  endtask

  task automatic chk_none(input string tag, input int idx);
    chk({tag, "_grant"}, 32'(grant), 32'd0);
    chk({tag, "_valid"}, 32'(gvalid), 32'd0);
    chk({tag, "_idx"},   32'(gidx), 32'(idx));
    chk({tag, "_tens"},  32'(gtens), 32'hF);
    chk({tag, "_ones"},  32'(gones), 32'hF);
  endtask

  // One full slice: four grant cycles followed by the one-cycle gap.
  task automatic run_grant(input string tag, input int idx);
    exp_count++;
    step();
    chk_grant({tag, "_c0"}, idx);
    chk({tag, "_count"}, 32'(gcount), 32'(exp_count));
    for (int c = 1; c < 4; c++) begin
      step();
      chk({tag, "_hold"}, 32'(grant), 32'(18'd1 << idx));
    end
    step();
    chk_none({tag, "_gap"}, idx);
  endtask

  initial begin
    n_assert  = 0;
    n_fail    = 0;
    exp_count = 0;
    rst_n     = 1'b0;
    req       = 18'h0;
    en        = 1'b0;

    // Reset state.
    step();
    step();
    chk_reset("reset");
    rst_n = 1'b1;

    // Idle with no requests.
    en = 1'b1;
    for (int c = 0; c < 20; c++) step();
    chk_reset("idle20");

    // All requesting: rotate 0..17 then back to 0.
    req = 18'h3FFFF;
    for (int g = 0; g < 19; g++) begin
      run_grant("rr_all", g % 18);
    end
    chk("rr_count19", 32'(gcount), 32'd19);

    // Sole requester 5 re-granted after each gap.
    req = 18'h00020;
    run_grant("solo5_a", 5);
    run_grant("solo5_b", 5);
    run_grant("solo5_c", 5);

    // Add requester 2: alternation 2,5,2,5.
    req = 18'h00024;
    run_grant("alt_2a", 2);
    run_grant("alt_5a", 5);
    run_grant("alt_2b", 2);
    run_grant("alt_5b", 5);

    // Requesters 3,9,12; 9 drops its request at hold count 1.
    req = 18'h01208;
    exp_count++;
    step();
    chk_grant("drop_g9", 9);
    step();
    chk_grant("drop_g9_h1", 9);
    req = 18'h01008;
    step();
    chk_none("drop_rel", 9);
    exp_count++;
    step();
    chk_grant("drop_next12", 12);
    chk("drop_count", 32'(gcount), 32'(exp_count));

    // Disable mid-grant: release and no further grants.
    step();
    chk_grant("en_g12_h1", 12);
    en = 1'b0;
    step();
    chk_none("en_off_rel", 12);
    for (int c = 0; c < 5; c++) step();
    chk_none("en_off_hold", 12);
    chk("en_off_count", 32'(gcount), 32'(exp_count));
    en = 1'b1;
    exp_count++;
    step();
    chk_grant("en_resume3", 3);
    chk("en_resume_count", 32'(gcount), 32'(exp_count));

    // Asynchronous reset mid-grant.
    step();
    chk_grant("rst_pre", 3);
    rst_n = 1'b0;
    #2;
    chk_reset("rst_async");
    req = 18'h3FFFF;
    step();
    step();
    chk_reset("rst_held");
    rst_n = 1'b1;
    step();
    chk_grant("rst_first0", 0);
    chk("rst_count1", 32'(gcount), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
